// File: rtl/servant_spi_slave.sv
// servant_spi_slave
// SPI mode-0 slave front end for the servant serial RAM. It decodes 23LC-style
// WRITE (0x02) / READ (0x03) frames with an MSB-first address and sequential
// bursts, drives the byte-wide RAM port and shifts read data out on MISO.
// Every SPI pin is oversampled on i_clk.
module servant_spi_slave #(
    parameter int depth      = 65536,
    parameter int aw         = $clog2(depth),
    parameter int ADDR_BYTES = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_sck,
    input  logic          i_cs_n,
    input  logic          i_mosi,
    output logic          o_miso,
    output logic          o_miso_oe,
    output logic [aw-1:0] o_ram_addr,
    output logic [7:0]    o_ram_wdata,
    output logic          o_ram_we_n,
    output logic          o_ram_re,
    input  logic [7:0]    i_ram_rdata
);

    localparam int AB  = 8 * ADDR_BYTES;
    localparam int BCW = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_RDATA,
        S_IGNORE
    } state_t;

    logic           r_sckMeta, r_sckSync, r_sckDly;
    logic           r_csMeta, r_csSync;
    logic           r_mosiMeta, r_mosiSync;
    logic [1:0]     r_flush;
    logic           r_armed;
    state_t         r_state;
    logic [2:0]     r_bitCnt;
    logic [BCW-1:0] r_byteCnt;
    logic           r_isWrite;
    logic [7:0]     r_rxShift;
    logic [AB-1:0]  r_addrShift;
    logic           r_capture;
    logic [7:0]     r_prefetch;
    logic [7:0]     r_txShift;

    logic           w_sckRise;
    logic           w_sckFall;
    logic           w_byteDone;
    logic [7:0]     w_rxByte;
    logic [AB-1:0]  w_addrNext;

    assign w_sckRise  = r_sckSync & ~r_sckDly;
    assign w_sckFall  = ~r_sckSync & r_sckDly;
    assign w_byteDone = w_sckRise && (r_bitCnt == 3'd7);
    assign w_rxByte   = {r_rxShift[6:0], r_mosiSync};
    assign w_addrNext = {r_addrShift[AB-2:0], r_mosiSync};
    assign o_miso     = r_txShift[7];

    // Two-flop synchronizers plus a delayed sck copy for edge detection; r_flush
    // marks when the synchronizers hold real pin values again after reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sckMeta  <= 1'b0;
            r_sckSync  <= 1'b0;
            r_sckDly   <= 1'b0;
            r_csMeta   <= 1'b1;
            r_csSync   <= 1'b1;
            r_mosiMeta <= 1'b0;
            r_mosiSync <= 1'b0;
            r_flush    <= 2'b00;
        end else begin
            r_sckMeta  <= i_sck;
            r_sckSync  <= r_sckMeta;
            r_sckDly   <= r_sckSync;
            r_csMeta   <= i_cs_n;
            r_csSync   <= r_csMeta;
            r_mosiMeta <= i_mosi;
            r_mosiSync <= r_mosiMeta;
            r_flush    <= {r_flush[0], 1'b1};
        end
    end

    // Frame decoder, RAM strobes, read prefetch and MISO shifter. A frame only
    // starts once cs_n has been seen high since reset, so a frame cut by reset
    // is ignored until the master deselects.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_armed     <= 1'b0;
            r_bitCnt    <= 3'd0;
            r_byteCnt   <= '0;
            r_isWrite   <= 1'b0;
            r_rxShift   <= 8'h00;
            r_addrShift <= '0;
            r_capture   <= 1'b0;
            r_prefetch  <= 8'h00;
            r_txShift   <= 8'h00;
            o_miso_oe   <= 1'b0;
            o_ram_addr  <= '0;
            o_ram_wdata <= 8'h00;
            o_ram_we_n  <= 1'b1;
            o_ram_re    <= 1'b0;
        end else begin
            o_ram_we_n <= 1'b1;
            o_ram_re   <= 1'b0;
            r_capture  <= o_ram_re;
            if (!o_ram_we_n) begin
                o_ram_addr <= o_ram_addr + 1'b1;
            end
            if (r_capture) begin
                r_prefetch <= i_ram_rdata;
                o_ram_addr <= o_ram_addr + 1'b1;
            end
            if (r_csSync) begin
                r_state   <= S_IDLE;
                r_bitCnt  <= 3'd0;
                r_txShift <= 8'h00;
                o_miso_oe <= 1'b0;
                if (r_flush[1]) begin
                    r_armed <= 1'b1;
                end
            end else begin
                if (w_sckRise && (r_state != S_IDLE)) begin
                    r_bitCnt  <= r_bitCnt + 3'd1;
                    r_rxShift <= w_rxByte;
                end
                case (r_state)
                    S_IDLE: begin
                        if (r_armed) begin
                            r_state   <= S_CMD;
                            r_bitCnt  <= 3'd0;
                            r_byteCnt <= '0;
                            o_miso_oe <= 1'b1;
                        end
                    end
                    S_CMD: begin
                        if (w_byteDone) begin
                            if (w_rxByte == 8'h02) begin
                                r_isWrite <= 1'b1;
                                r_state   <= S_ADDR;
                            end else if (w_rxByte == 8'h03) begin
                                r_isWrite <= 1'b0;
                                r_state   <= S_ADDR;
                            end else begin
                                r_state <= S_IGNORE;
                            end
                        end
                    end
                    S_ADDR: begin
                        if (w_sckRise) begin
                            r_addrShift <= w_addrNext;
                            if (r_bitCnt == 3'd7) begin
                                r_byteCnt <= r_byteCnt + 1'b1;
                                if (r_byteCnt == BCW'(ADDR_BYTES - 1)) begin
                                    o_ram_addr <= w_addrNext[aw-1:0];
                                    if (r_isWrite) begin
                                        r_state <= S_WDATA;
                                    end else begin
                                        r_state  <= S_RDATA;
                                        o_ram_re <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    S_WDATA: begin
                        if (w_byteDone) begin
                            o_ram_wdata <= w_rxByte;
                            o_ram_we_n  <= 1'b0;
                        end
                    end
                    S_RDATA: begin
                        if (w_byteDone) begin
                            o_ram_re <= 1'b1;
                        end
                        if (w_sckFall) begin
                            if (r_bitCnt == 3'd0) begin
                                r_txShift <= r_prefetch;
                            end else begin
                                r_txShift <= {r_txShift[6:0], 1'b0};
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_servant_spi_slave.sv
// tb_servant_spi_slave
// Directed frames against a behavioural byte RAM; write strobes and read
// enables are logged and compared with hand-computed expectations.
module tb_servant_spi_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        sck;
    logic        csN;
    logic        mosi;
    logic        miso;
    logic        misoOe;
    logic [15:0] ramAddr;
    logic [7:0]  ramWdata;
    logic        ramWeN;
    logic        ramRe;
    logic [7:0]  ramRdata = 8'h00;

    logic [7:0]  mem [0:65535];
    logic [15:0] logAddr [$];
    logic [7:0]  logData [$];
    int          reCnt = 0;
    int          bothCnt = 0;
    int          misoHighCnt = 0;
    int          compared = 0;
    int          mismatched = 0;
    logic [7:0]  rxA;
    logic [7:0]  rxB;

    servant_spi_slave dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_sck       (sck),
        .i_cs_n      (csN),
        .i_mosi      (mosi),
        .o_miso      (miso),
        .o_miso_oe   (misoOe),
        .o_ram_addr  (ramAddr),
        .o_ram_wdata (ramWdata),
        .o_ram_we_n  (ramWeN),
        .o_ram_re    (ramRe),
        .i_ram_rdata (ramRdata)
    );

    // 100 MHz system clock
    always #5 clk = ~clk;

    // Byte RAM: write on strobe, read data valid the cycle after read enable
    always @(posedge clk) begin
        if (!ramWeN) mem[ramAddr] <= ramWdata;
        if (ramRe) ramRdata <= mem[ramAddr];
    end

    // Log every strobe cycle away from the active edge
    always @(negedge clk) begin
        if (!ramWeN) begin
            logAddr.push_back(ramAddr);
            logData.push_back(ramWdata);
        end
        if (ramRe) reCnt++;
        if (!ramWeN && ramRe) bothCnt++;
        if (miso) misoHighCnt++;
    end

    // Hard time limit so a stuck DUT still ends the run
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Shift nBits of txByte out MSB first (mode 0, 80 ns half period) and
    // collect MISO just before each rising edge
    task automatic applyStimulus(input logic [7:0] txByte, input int nBits, output logic [7:0] rxByte);
        rxByte = 8'h00;
        for (int i = 0; i < nBits; i++) begin
            mosi = txByte[7-i];
            #80;
            rxByte = {rxByte[6:0], miso};
            sck = 1'b1;
            #80;
            sck = 1'b0;
        end
    endtask

    task automatic startFrame();
        csN = 1'b0;
        #100;
    endtask

    task automatic endFrame();
        #100;
        csN = 1'b1;
        #300;
    endtask

    task automatic clearLogs();
        @(posedge clk);
        #1;
        logAddr.delete();
        logData.delete();
        reCnt = 0;
        misoHighCnt = 0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        logic [7:0] dummy;
        applyStimulus(b, 8, dummy);
    endtask

    initial begin
        rst  = 1'b1;
        sck  = 1'b0;
        csN  = 1'b1;
        mosi = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        #23;
        checkOutput("rst_miso", {31'd0, miso}, 32'd0);
        checkOutput("rst_oe", {31'd0, misoOe}, 32'd0);
        checkOutput("rst_addr", {16'd0, ramAddr}, 32'd0);
        checkOutput("rst_wdata", {24'd0, ramWdata}, 32'd0);
        checkOutput("rst_we_n", {31'd0, ramWeN}, 32'd1);
        checkOutput("rst_re", {31'd0, ramRe}, 32'd0);
        rst = 1'b0;
        #100;

        $display("[TB] test 1: single write");
        clearLogs();
        startFrame();
        sendByte(8'h02); sendByte(8'h12); sendByte(8'h34); sendByte(8'hA5);
        endFrame();
        checkOutput("t1_we_count", logAddr.size(), 32'd1);
        if (logAddr.size() >= 1) begin
            checkOutput("t1_addr", {16'd0, logAddr[0]}, 32'h1234);
            checkOutput("t1_wdata", {24'd0, logData[0]}, 32'hA5);
        end
        checkOutput("t1_mem", {24'd0, mem[16'h1234]}, 32'hA5);
        checkOutput("t1_addr_inc", {16'd0, ramAddr}, 32'h1235);
        checkOutput("t1_re_count", reCnt, 32'd0);

        $display("[TB] test 2: burst write with wrap");
        clearLogs();
        startFrame();
        sendByte(8'h02); sendByte(8'hFF); sendByte(8'hFF); sendByte(8'h11); sendByte(8'h22);
        endFrame();
        checkOutput("t2_we_count", logAddr.size(), 32'd2);
        if (logAddr.size() >= 2) begin
            checkOutput("t2_addr0", {16'd0, logAddr[0]}, 32'hFFFF);
            checkOutput("t2_data0", {24'd0, logData[0]}, 32'h11);
            checkOutput("t2_addr1", {16'd0, logAddr[1]}, 32'h0000);
            checkOutput("t2_data1", {24'd0, logData[1]}, 32'h22);
        end
        checkOutput("t2_addr_final", {16'd0, ramAddr}, 32'h0001);

        $display("[TB] test 3: burst read");
        mem[16'h1235] = 8'h5A;
        clearLogs();
        startFrame();
        sendByte(8'h03); sendByte(8'h12); sendByte(8'h34);
        checkOutput("t3_oe", {31'd0, misoOe}, 32'd1);
        applyStimulus(8'h00, 8, rxA);
        applyStimulus(8'h00, 8, rxB);
        endFrame();
        checkOutput("t3_byte0", {24'd0, rxA}, 32'hA5);
        checkOutput("t3_byte1", {24'd0, rxB}, 32'h5A);
        checkOutput("t3_re_count", reCnt, 32'd3);
        checkOutput("t3_we_count", logAddr.size(), 32'd0);
        checkOutput("t3_addr_final", {16'd0, ramAddr}, 32'h1237);
        checkOutput("t3_oe_after", {31'd0, misoOe}, 32'd0);

        $display("[TB] test 4: partial byte discarded");
        clearLogs();
        startFrame();
        sendByte(8'h02); sendByte(8'h00); sendByte(8'h10);
        applyStimulus(8'hC3, 5, rxA);
        endFrame();
        checkOutput("t4_partial_we", logAddr.size(), 32'd0);
        startFrame();
        sendByte(8'h02); sendByte(8'h00); sendByte(8'h10); sendByte(8'h3C);
        endFrame();
        checkOutput("t4_we_count", logAddr.size(), 32'd1);
        checkOutput("t4_mem", {24'd0, mem[16'h0010]}, 32'h3C);

        $display("[TB] test 5: unknown command");
        mem[16'h0000] = 8'hFF;
        clearLogs();
        startFrame();
        sendByte(8'h9F); sendByte(8'h00); sendByte(8'h00); sendByte(8'h00);
        endFrame();
        checkOutput("t5_we_count", logAddr.size(), 32'd0);
        checkOutput("t5_re_count", reCnt, 32'd0);
        checkOutput("t5_miso_high", misoHighCnt, 32'd0);

        $display("[TB] test 6: reset mid-read");
        startFrame();
        sendByte(8'h03); sendByte(8'h12); sendByte(8'h34);
        applyStimulus(8'h00, 4, rxA);
        mosi = 1'b0;
        #40;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("t6_miso", {31'd0, miso}, 32'd0);
        checkOutput("t6_oe", {31'd0, misoOe}, 32'd0);
        checkOutput("t6_addr", {16'd0, ramAddr}, 32'd0);
        checkOutput("t6_we_n", {31'd0, ramWeN}, 32'd1);
        checkOutput("t6_re", {31'd0, ramRe}, 32'd0);
        checkOutput("t6_wdata", {24'd0, ramWdata}, 32'd0);
        #30;
        rst = 1'b0;
        clearLogs();
        sck = 1'b1;
        #80;
        sck = 1'b0;
        applyStimulus(8'h03, 3, rxA);
        sendByte(8'h02);
        sendByte(8'h55);
        checkOutput("t6_ignored_re", reCnt, 32'd0);
        checkOutput("t6_ignored_we", logAddr.size(), 32'd0);
        checkOutput("t6_ignored_oe", {31'd0, misoOe}, 32'd0);
        endFrame();
        startFrame();
        sendByte(8'h03); sendByte(8'h12); sendByte(8'h35);
        applyStimulus(8'h00, 8, rxA);
        endFrame();
        checkOutput("t6_read_after", {24'd0, rxA}, 32'h5A);
        checkOutput("t6_mem_kept", {24'd0, mem[16'h1234]}, 32'hA5);

        checkOutput("strobe_overlap", bothCnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
